// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand/opcode entry sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_OP1    = 3'd0,
    S_OP2    = 3'd1,
    S_OPCODE = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [3:0] OP_UP    = 4'b1000;
  localparam logic [3:0] OP_DOWN  = 4'b0100;
  localparam logic [3:0] OP_RIGHT = 4'b0010;
  localparam logic [3:0] OP_LEFT  = 4'b0001;

  // True when exactly one of the four button bits is set.
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Walks the user through entering A, B and an opcode, then captures the
// ALU result and status for display.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [N-1:0] data_in,
  input  logic         enter,
  input  logic         undo,
  input  logic [3:0]   op_btn,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_status,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [3:0]   op_q,
  output logic [N-1:0] result_q,
  output logic [3:0]   status_q,
  output logic         done,
  output logic [2:0]   stage,
  output logic [N-1:0] display_value
);

  state_t state, state_n;
  logic   load_a, load_b, load_op, load_res;

  // State register; codes outside the enum fall back to S_OP1 via next-state.
  always_ff @(posedge clk) begin
    if (!resetN) state <= S_OP1;
    else         state <= state_n;
  end

  // Next-state and register load enables; undo outranks enter and op_btn.
  always_comb begin
    state_n  = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_op  = 1'b0;
    load_res = 1'b0;
    case (state)
      S_OP1: begin
        if (enter && !undo) begin
          load_a  = 1'b1;
          state_n = S_OP2;
        end
      end
      S_OP2: begin
        if (undo) begin
          state_n = S_OP1;
        end else if (enter) begin
          load_b  = 1'b1;
          state_n = S_OPCODE;
        end
      end
      S_OPCODE: begin
        if (undo) begin
          state_n = S_OP2;
        end else if (onehot4(op_btn)) begin
          load_op = 1'b1;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        load_res = 1'b1;
        state_n  = S_RESULT;
      end
      S_RESULT: begin
        if (undo)       state_n = S_OPCODE;
        else if (enter) state_n = S_OP1;
      end
      default: state_n = S_OP1;
    endcase
  end

  // Operand, opcode and result registers plus the registered done pulse.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      status_q <= '0;
      done     <= 1'b0;
    end else begin
      if (load_a)   a_q  <= data_in;
      if (load_b)   b_q  <= data_in;
      if (load_op)  op_q <= op_btn;
      if (load_res) begin
        result_q <= alu_result;
        status_q <= alu_status;
      end
      done <= load_res;
    end
  end

  assign stage = state;

  // Display source follows the current entry stage.
  always_comb begin
    display_value = data_in;
    case (state)
      S_OPCODE, S_EXEC: display_value = b_q;
      S_RESULT:         display_value = result_q;
      default:          display_value = data_in;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU beside it.
module tb_alu_seq_ctrl;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         resetN;
  logic [N-1:0] data_in;
  logic         enter, undo;
  logic [3:0]   op_btn;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_status;
  logic [N-1:0] a_q, b_q, result_q, display_value;
  logic [3:0]   op_q, status_q;
  logic         done;
  logic [2:0]   stage;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_seq_ctrl #(.N(N)) dut (
    .clk(clk), .resetN(resetN), .data_in(data_in), .enter(enter),
    .undo(undo), .op_btn(op_btn), .alu_result(alu_result),
    .alu_status(alu_status), .a_q(a_q), .b_q(b_q), .op_q(op_q),
    .result_q(result_q), .status_q(status_q), .done(done),
    .stage(stage), .display_value(display_value)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: UP add, DOWN sub, RIGHT or, LEFT and.
  // Status = {add carry, result msb, result zero, 0}.
  logic [N:0] sum;
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    alu_result = '0;
    case (op_q)
      4'b1000: alu_result = sum[N-1:0];
      4'b0100: alu_result = a_q - b_q;
      4'b0010: alu_result = a_q | b_q;
      4'b0001: alu_result = a_q & b_q;
      default: alu_result = '0;
    endcase
    alu_status = {(op_q == 4'b1000) & sum[N], alu_result[N-1],
                  (alu_result == '0), 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_enter(input logic [N-1:0] v);
    data_in = v; enter = 1'b1; step(); enter = 1'b0;
  endtask

  task automatic do_undo();
    undo = 1'b1; step(); undo = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    op_btn = b; step(); op_btn = 4'b0000;
  endtask

  // Press a valid op, verify the 2-cycle latency and single done pulse.
  task automatic run_op(input string tag, input logic [3:0] b,
                        input logic [N-1:0] res, input logic [3:0] st);
    press(b);
    check({tag, "_exec_stage"}, stage, 3);
    check({tag, "_exec_done"}, done, 0);
    check({tag, "_op_q"}, op_q, b);
    step();
    check({tag, "_done"}, done, 1);
    check({tag, "_stage"}, stage, 4);
    check({tag, "_result"}, result_q, res);
    check({tag, "_status"}, status_q, st);
    check({tag, "_disp"}, display_value, res);
    step();
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    resetN = 1'b0; data_in = '0; enter = 1'b0; undo = 1'b0; op_btn = '0;
    step(); step();
    check("rst_stage", stage, 0);
    check("rst_a", a_q, 0);
    check("rst_b", b_q, 0);
    check("rst_op", op_q, 0);
    check("rst_res", result_q, 0);
    check("rst_stat", status_q, 0);
    check("rst_done", done, 0);
    resetN = 1'b1;

    // 200 + 100 wraps to 44 with carry.
    do_undo();
    check("undo_op1_ignored", stage, 0);
    do_enter(8'd200);
    check("a_load", a_q, 200);
    check("stage_op2", stage, 1);
    do_enter(8'd100);
    check("b_load", b_q, 100);
    check("stage_opc", stage, 2);
    check("disp_opc", display_value, 100);
    run_op("add", 4'b1000, 8'd44, 4'b1000);
    do_enter(8'd0);
    check("res_to_op1", stage, 0);
    check("res_held", result_q, 44);
    check("op_held", op_q, 4'b1000);
    data_in = 8'h5A; #1;
    check("disp_op1", display_value, 8'h5A);

    // 5 - 7 = FE.
    do_enter(8'd5);
    do_enter(8'd7);
    run_op("sub", 4'b0100, 8'hFE, 4'b0100);

    // Invalid op buttons and enter are ignored in S_OPCODE.
    do_enter(8'd0);
    do_enter(8'hF0);
    do_enter(8'h3C);
    press(4'b0110);
    check("multi_stage", stage, 2);
    check("multi_op", op_q, 4'b0100);
    check("multi_done", done, 0);
    press(4'b0000);
    check("zero_stage", stage, 2);
    check("zero_op", op_q, 4'b0100);
    do_enter(8'h99);
    check("enter_opc_ign", stage, 2);
    check("enter_opc_b", b_q, 8'h3C);
    run_op("and", 4'b0001, 8'h30, 4'b0000);

    // Undo from S_RESULT reuses A and B for a new op.
    do_enter(8'd0);
    do_enter(8'h0F);
    do_enter(8'hF0);
    run_op("and0", 4'b0001, 8'h00, 4'b0010);
    do_undo();
    check("undo_res", stage, 2);
    run_op("or", 4'b0010, 8'hFF, 4'b0100);

    // undo beats enter in S_OP2; undo beats a valid op in S_OPCODE.
    do_enter(8'd0);
    do_enter(8'h11);
    data_in = 8'h22; enter = 1'b1; undo = 1'b1; step(); enter = 1'b0; undo = 1'b0;
    check("ue_stage", stage, 0);
    check("ue_b", b_q, 8'hF0);
    check("ue_a", a_q, 8'h11);
    do_enter(8'h11);
    do_enter(8'h22);
    op_btn = 4'b1000; undo = 1'b1; step(); op_btn = '0; undo = 1'b0;
    check("uop_stage", stage, 1);
    check("uop_op", op_q, 4'b0010);

    // Reset during S_EXEC, with a pending enter that must be discarded.
    do_enter(8'h22);
    press(4'b1000);
    check("pre_rst_exec", stage, 3);
    resetN = 1'b0; enter = 1'b1; data_in = 8'h99;
    step();
    resetN = 1'b1; enter = 1'b0;
    check("mrst_stage", stage, 0);
    check("mrst_done", done, 0);
    check("mrst_a", a_q, 0);
    check("mrst_b", b_q, 0);
    check("mrst_op", op_q, 0);
    check("mrst_res", result_q, 0);
    check("mrst_stat", status_q, 0);
    step();
    check("mrst_done2", done, 0);
    check("mrst_stage2", stage, 0);
    do_enter(8'd3);
    do_enter(8'd4);
    run_op("resume", 4'b1000, 8'd7, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operand/opcode entry sequencer that drives the shared N-bit ALU from switch and button inputs. It walks the user through entering A, entering B, and picking an operation. It then latches the ALU result and status into output registers for display. It sits between the debounced board inputs and the ALU / 7-segment display path.

## Interface
- N, 8, operand/result width; must match the ALU width.
- clk  in  1  system clock.
- resetN  in  1  synchronous, active-low reset.
- data_in  in  N  operand switches, sampled on enter.
- enter  in  1  single-cycle pulse, already debounced/edge-detected.
- undo  in  1  single-cycle pulse, steps back one stage.
- op_btn  in  4  single-cycle one-hot button pulses {UP,DOWN,RIGHT,LEFT}.
- alu_result  in  N  combinational ALU result for (a_q, b_q, op_q).
- alu_status  in  4  combinational ALU status.
- a_q  out  N  latched operand A to ALU.
- b_q  out  N  latched operand B to ALU.
- op_q  out  4  latched one-hot opcode to ALU.
- result_q  out  N  latched result.
- status_q  out  4  latched status.
- done  out  1  one-cycle pulse when result_q/status_q update.
- stage  out  3  one-hot-free state code (see Operation).
- display_value  out  N  value for display mux.

## Operation
- States and stage codes: S_OP1=0, S_OP2=1, S_OPCODE=2, S_EXEC=3, S_RESULT=4.
- Transitions from S_OP1:
  - enter: a_q <= data_in, go to S_OP2.
  - undo: ignored.
- Transitions from S_OP2:
  - enter: b_q <= data_in, go to S_OPCODE.
  - undo: go to S_OP1 (a_q retained).
- Transitions from S_OPCODE:
  - Valid op_btn (exactly one bit set): op_q <= op_btn, go to S_EXEC.
  - Zero or multi-hot op_btn: ignored.
  - enter: ignored.
  - undo: go to S_OP2.
- S_EXEC lasts exactly one cycle: result_q <= alu_result, status_q <= alu_status, done=1, go to S_RESULT.
- Transitions from S_RESULT:
  - enter: go to S_OP1; result_q, status_q and op_q are held until overwritten.
  - undo: go to S_OPCODE, allowing a new operation on the same A and B.
  - op_btn: ignored.
- Simultaneous events:
  - undo has priority over enter and op_btn in the same cycle.
  - In S_OPCODE, a valid op_btn has priority over enter.
- display_value:
  - data_in in S_OP1 and S_OP2.
  - b_q in S_OPCODE and S_EXEC.
  - result_q in S_RESULT.
- Arithmetic and status semantics belong to the ALU; this block passes values through unchanged.
  - Add/subtract wrap modulo 2^N.
  - An invalid opcode never reaches op_q.
- Unreachable state codes 5–7 return to S_OP1 on the next clock.

## Timing
- All registers update on the rising edge of clk.
- Reset is sampled only at the edge, with resetN=0, and forces:
  - state S_OP1, stage 3'd0.
  - a_q, b_q, op_q, result_q, status_q = 0.
  - done = 0.
- Reset mid-operation: any state returns to S_OP1 at the next edge; a pending enter or op_btn in that same cycle is discarded.
- Latency, op_btn to result:
  - Edge k: op_btn sampled, op_q loaded.
  - Edge k+1: result_q loaded, done high for the cycle after edge k+1.
  - Latency is 2 cycles.
- done is never high for two consecutive cycles.
- Input pulses held longer than one cycle are treated as repeated events (upstream guarantees single-cycle).

## Structure
- Package alu_seq_pkg holds:
  - state_t enum (S_OP1..S_RESULT, 3-bit).
  - localparams OP_UP=4'b1000, OP_DOWN=4'b0100, OP_RIGHT=4'b0010, OP_LEFT=4'b0001.
  - onehot4() validity function.
- No sub-modules: the ALU is instantiated beside this block at the top level. A single FSM plus a register file is the whole block.

## Test plan
- A=200, B=100, UP: result_q=8'd44, status_q=4'b1000, done exactly 2 cycles after the op_btn pulse, stage=4.
- A=5, B=7, DOWN: result_q=8'hFE, status_q=4'b0100; display_value=8'hFE in S_RESULT.
- In S_OPCODE apply op_btn=4'b0110, then 4'b0000: state stays 2, op_q unchanged, no done; then LEFT with A=8'hF0, B=8'h3C gives result_q=8'h30.
- Undo chain:
  - From S_RESULT: undo then RIGHT with A=8'h0F, B=8'hF0 gives 8'hFF.
  - undo+enter together in S_OP2 returns to S_OP1 with b_q unchanged.
- Assert resetN=0 for one cycle during S_EXEC: next cycle all outputs are 0, stage=0, done=0; resume normal entry afterwards.
